// File: rtl/protobuf_field_encoder.sv
// Protobuf field encoder: one scalar per input transaction becomes an optional varint key
// followed by a varint, zigzag-varint, fixed32 or fixed64 value on an 8-bit valid/ready stream.
module protobuf_field_encoder #(
  parameter int DATA_W  = 64,
  parameter int FIELD_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               clock_clk,
  input  logic               reset_reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [FIELD_W-1:0] in_field,
  input  logic [1:0]         in_mode,
  input  logic               in_tag_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_last,
  output logic [CNT_W-1:0]   byte_cnt,
  input  logic               cnt_clr
);

  typedef enum logic [1:0] {IDLE, KEY, VAL} state_t;

  state_t           state_q;
  logic             out_valid_q, out_last_q;
  logic [7:0]       out_data_q;
  logic [CNT_W-1:0] cnt_q;

  // Remaining, not-yet-emitted content of the field being encoded.
  logic [63:0] key_q, val_q;
  logic        fixed_q;
  logic [3:0]  fcnt_q;

  logic [63:0] key_d, val_d;
  logic        fixed_d;
  logic [3:0]  fcnt_d;
  logic [2:0]  wt_d;
  logic        xfer, load_in, adv, key_step, val_step;

  function automatic logic [7:0] head_byte(input logic [63:0] v, input logic fx);
    return fx ? v[7:0] : {|v[63:7], v[6:0]};
  endfunction

  function automatic logic [63:0] tail_bits(input logic [63:0] v, input logic fx);
    return fx ? (v >> 8) : (v >> 7);
  endfunction

  function automatic logic head_is_last(input logic [63:0] v, input logic fx, input logic [3:0] n);
    return fx ? (n == 4'd1) : ~|v[63:7];
  endfunction

  always_comb begin
    val_d = '0;
    key_d = '0;
    case (in_mode)
      2'b00:   val_d[DATA_W-1:0] = in_data;
      2'b01:   val_d[DATA_W-1:0] = (in_data << 1) ^ {DATA_W{in_data[DATA_W-1]}};
      2'b10:   val_d[31:0]       = in_data[31:0];
      default: val_d[DATA_W-1:0] = in_data;
    endcase
    case (in_mode)
      2'b10:   wt_d = 3'd5;
      2'b11:   wt_d = 3'd1;
      default: wt_d = 3'd0;
    endcase
    key_d[FIELD_W+2:0] = {in_field, wt_d};
    fixed_d = in_mode[1];
    fcnt_d  = in_mode[0] ? 4'd8 : 4'd4;
  end

  assign in_ready = (state_q == IDLE) && !reset_reset;
  assign xfer     = out_valid_q && out_ready;
  assign load_in  = in_valid && in_ready;
  assign adv      = xfer && !out_last_q;
  assign key_step = adv && (state_q == KEY) && |key_q;
  assign val_step = adv && ((state_q == VAL) || ((state_q == KEY) && !(|key_q)));

  // Field content registers hold no control meaning, so they are left out of reset.
  always_ff @(posedge clock_clk) begin
    if (load_in) begin
      key_q   <= key_d >> 7;
      val_q   <= in_tag_en ? val_d  : tail_bits(val_d, fixed_d);
      fcnt_q  <= in_tag_en ? fcnt_d : fcnt_d - 4'd1;
      fixed_q <= fixed_d;
    end else if (key_step) begin
      key_q <= key_q >> 7;
    end else if (val_step) begin
      val_q  <= tail_bits(val_q, fixed_q);
      fcnt_q <= fcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (xfer)         cnt_q <= cnt_clr ? CNT_W'(1) : cnt_q + CNT_W'(1);
      else if (cnt_clr) cnt_q <= '0;

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            out_valid_q <= 1'b1;
            if (in_tag_en) begin
              state_q    <= KEY;
              out_data_q <= head_byte(key_d, 1'b0);
              out_last_q <= 1'b0;
            end else begin
              state_q    <= VAL;
              out_data_q <= head_byte(val_d, fixed_d);
              out_last_q <= head_is_last(val_d, fixed_d, fcnt_d);
            end
          end
        end
        KEY: begin
          if (xfer) begin
            if (|key_q) begin
              out_data_q <= head_byte(key_q, 1'b0);
            end else begin
              state_q    <= VAL;
              out_data_q <= head_byte(val_q, fixed_q);
              out_last_q <= head_is_last(val_q, fixed_q, fcnt_q);
            end
          end
        end
        VAL: begin
          if (xfer) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              out_data_q <= head_byte(val_q, fixed_q);
              out_last_q <= head_is_last(val_q, fixed_q, fcnt_q);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_protobuf_field_encoder.sv
// Self-checking bench for protobuf_field_encoder (DATA_W=64) against a queue-based reference model.
module tb_protobuf_field_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [9:0]  in_field = '0;
  logic [1:0]  in_mode = '0;
  logic        in_tag_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] byte_cnt;
  logic        cnt_clr = 1'b0;

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] cnt_exp = '0;

  always #5 clk = ~clk;

  protobuf_field_encoder #(.DATA_W(64), .FIELD_W(10), .CNT_W(16)) dut (
    .clock_clk  (clk),
    .reset_reset(rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_field   (in_field),
    .in_mode    (in_mode),
    .in_tag_en  (in_tag_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .byte_cnt   (byte_cnt),
    .cnt_clr    (cnt_clr)
  );

  // Drives one field, collects its bytes and compares them with the reference encoding.
  task automatic run_field(input logic [63:0] d, input int f, input logic [1:0] m,
                           input logic te, input bit rnd, input bit clr_last, input string nm);
    logic [7:0]  exp[$];
    logic [63:0] v, z;
    longint      sd;
    int          wt, idx, cyc, t;
    bit          stalled;
    logic [7:0]  held_d;
    logic        held_l;
    exp = {};
    wt = (m == 2'b10) ? 5 : (m == 2'b11) ? 1 : 0;
    if (te) begin
      v = 64'(f) * 64'd8 + 64'(wt);
      do begin
        exp.push_back(8'(v % 128) | ((v / 128) != 0 ? 8'h80 : 8'h00));
        v = v / 128;
      end while (v != 0);
    end
    if (m == 2'b10 || m == 2'b11) begin
      v = (m == 2'b10) ? (d % 64'h1_0000_0000) : d;
      for (int i = 0; i < ((m == 2'b10) ? 4 : 8); i++) begin
        exp.push_back(8'(v % 256));
        v = v / 256;
      end
    end else begin
      if (m == 2'b01) begin
        sd = d;
        z  = (sd >= 0) ? d * 2 : 64'(-(sd + 1)) * 2 + 1;
        v  = z;
      end else begin
        v = d;
      end
      do begin
        exp.push_back(8'(v % 128) | ((v / 128) != 0 ? 8'h80 : 8'h00));
        v = v / 128;
      end while (v != 0);
    end

    @(negedge clk);
    in_data = d; in_field = 10'(f); in_mode = m; in_tag_en = te; in_valid = 1'b1; out_ready = 1'b0;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: in_ready=%b required 1 within 20 cycles", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom}; in_field = 10'($urandom); in_mode = 2'($urandom); in_tag_en = 1'($urandom);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s latency: out_valid=%b required 1", nm, out_valid);
    end
    idx = 0; cyc = 0; stalled = 0; held_d = '0; held_l = 1'b0;
    while (idx < exp.size() && cyc < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        checks++;
        if (out_data !== held_d || out_last !== held_l) begin
          fails++;
          $display("FAIL %s stall: data=%h last=%b required data=%h last=%b", nm, out_data, out_last, held_d, held_l);
        end
      end
      if (out_valid !== 1'b1) begin
        checks++;
        fails++;
        $display("FAIL %s valid_drop: out_valid=%b required 1 at byte %0d", nm, out_valid, idx);
      end else if (out_ready) begin
        checks++;
        if (out_data !== exp[idx] || out_last !== (idx == exp.size() - 1)) begin
          fails++;
          $display("FAIL %s byte%0d: data=%h last=%b required data=%h last=%b", nm, idx, out_data, out_last,
                   exp[idx], (idx == exp.size() - 1));
        end
        if (clr_last && idx == exp.size() - 1) cnt_clr = 1'b1;
        idx++;
        stalled = 0;
      end else begin
        stalled = 1;
        held_d = out_data;
        held_l = out_last;
      end
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < exp.size()) begin
      checks++;
      fails++;
      $display("FAIL %s timeout: got %0d bytes required %0d", nm, idx, exp.size());
    end
    cnt_exp = clr_last ? 16'd1 : cnt_exp + 16'(exp.size());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s bubble: out_valid=%b in_ready=%b required 0 1", nm, out_valid, in_ready);
    end
    checks++;
    if (byte_cnt !== cnt_exp) begin
      fails++;
      $display("FAIL %s byte_cnt: %0d required %0d", nm, byte_cnt, cnt_exp);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || byte_cnt !== 16'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h last=%b cnt=%0d in_ready=%b required 0 00 0 0 0",
               out_valid, out_data, out_last, byte_cnt, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_exp = '0;
  endtask

  task automatic test_vectors();
    run_field(64'd300, 1, 2'b00, 1'b1, 0, 0, "T1_uint300");
    run_field(64'hFFFF_FFFF_FFFF_FFFF, 2, 2'b01, 1'b1, 0, 0, "T2_sint_m1");
    run_field(64'hFFFF_FFFF_FFFF_FFFE, 2, 2'b01, 1'b1, 0, 0, "T2_sint_m2");
    run_field(64'd1, 2, 2'b01, 1'b1, 0, 0, "T2_sint_p1");
    run_field(64'h1234_5678, 3, 2'b10, 1'b1, 0, 0, "T3_fixed32");
    run_field(64'd1, 1, 2'b11, 1'b1, 0, 0, "T3_fixed64");
    run_field(64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b00, 1'b0, 0, 0, "T4_uint_max");
    run_field(64'd0, 1, 2'b00, 1'b0, 0, 0, "T4_zero");
    run_field(64'd5, 16, 2'b00, 1'b1, 0, 0, "T4_field16");
    run_field(64'h8000_0000_0000_0000, 1023, 2'b01, 1'b1, 0, 0, "sint_min");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) run_field(64'd300, 1, 2'b00, 1'b1, 1, 0, "T5_stall");
    run_field(64'h0123_4567_89AB_CDEF, 7, 2'b11, 1'b1, 1, 0, "T5_stall_f64");
  endtask

  task automatic test_cnt_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    cnt_exp = '0;
    checks++;
    if (byte_cnt !== 16'd0) begin
      fails++;
      $display("FAIL cnt_clr_idle: byte_cnt=%0d required 0", byte_cnt);
    end
    run_field(64'd300, 1, 2'b00, 1'b1, 0, 1, "cnt_clr_xfer");
    run_field(64'd300, 1, 2'b00, 1'b1, 0, 0, "cnt_after_clr");
  endtask

  task automatic test_random();
    logic [63:0] d;
    for (int i = 0; i < 25; i++) begin
      d = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_field(d, $urandom_range(1, 1023), 2'($urandom), 1'($urandom), 1'($urandom), 0, "random");
    end
  endtask

  task automatic test_reset_mid_field();
    @(negedge clk);
    in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_field = 10'd1; in_mode = 2'b00; in_tag_en = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (byte_cnt !== cnt_exp + 16'd2 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL T6_pre: byte_cnt=%0d valid=%b required %0d 1", byte_cnt, out_valid, cnt_exp + 16'd2);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || byte_cnt !== 16'd0 || in_ready !== 1'b0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL T6_async: valid=%b cnt=%0d in_ready=%b last=%b required 0 0 0 0",
               out_valid, byte_cnt, in_ready, out_last);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    cnt_exp = '0;
    run_field(64'd300, 1, 2'b00, 1'b1, 0, 0, "T6_after");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_cnt_clr();
    test_random();
    test_reset_mid_field();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
